ff_frame_assembler: RTL and testbench

//  Upstream stage of the order-book top: packs a byte stream (valid/ready, sop/eop) into 41-byte frames.

---
 rtl/ff_frame_assembler.sv | 158 +++++++++++++++
 tb/tb_ff_frame_assembler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ff_frame_assembler.sv
// Packs a sop/eop-delimited byte stream into fixed-length frames. An assembly buffer
// feeds a hold register, so input can keep flowing while a finished frame waits.
module ff_frame_assembler #(
   parameter int unsigned FRAME_BYTES = 41,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_sop,
   input  logic                     in_eop,
   output logic                     in_ready,
   input  logic                     system_free,
   output logic                     buffer_not_empty,
   output logic [FRAME_BYTES*8-1:0] ff_buffer,
   output logic [CNT_W-1:0]         frame_count,
   output logic [CNT_W-1:0]         drop_count
);

   localparam int unsigned IDX_W = $clog2(FRAME_BYTES + 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCollect = 2'd1;
   localparam logic [1:0] StDiscard = 2'd2;
   localparam logic [1:0] StPending = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [FRAME_BYTES*8-1:0] asm_q, asm_d;
   logic [FRAME_BYTES*8-1:0] hold_q, hold_d;
   logic                     hold_valid_q, hold_valid_d;
   logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
   logic [CNT_W:0]           drop_sum;

   logic        accept, consume, hold_free;
   logic        start, take, complete, move;
   logic [1:0]  drop_inc;
   int unsigned pos;

   assign in_ready  = (state_q != StPending);
   assign accept    = in_valid && in_ready;
   assign consume   = hold_valid_q && system_free;
   assign hold_free = !hold_valid_q || consume;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      asm_d    = asm_q;
      start    = 1'b0;
      take     = 1'b0;
      complete = 1'b0;
      move     = 1'b0;
      drop_inc = 2'd0;
      pos      = 0;

      case (state_q)
         StIdle: begin
            if (accept && in_sop) start = 1'b1;
         end
         StCollect: begin
            if (accept) begin
               // A sop mid-frame abandons the partial frame and restarts on this byte.
               if (in_sop) begin
                  drop_inc = 2'd1;
                  start    = 1'b1;
               end else begin
                  take = 1'b1;
               end
            end
         end
         StDiscard: begin
            if (accept) begin
               if (in_sop) start = 1'b1;
               else if (in_eop) state_d = StIdle;
            end
         end
         StPending: begin
            if (hold_free) begin
               move    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (start || take) begin
         pos = start ? 0 : int'(idx_q);
         asm_d[(FRAME_BYTES-1-pos)*8 +: 8] = in_data;
         if (in_eop) begin
            if (pos + 1 == FRAME_BYTES) complete = 1'b1;
            else drop_inc = drop_inc + 2'd1;
            state_d = StIdle;
            idx_d   = '0;
         end else if (pos + 1 == FRAME_BYTES) begin
            drop_inc = drop_inc + 2'd1;
            state_d  = StDiscard;
            idx_d    = '0;
         end else begin
            idx_d   = IDX_W'(pos + 1);
            state_d = StCollect;
         end
      end

      if (complete) begin
         if (hold_free) begin
            move    = 1'b1;
            state_d = StIdle;
         end else begin
            state_d = StPending;
         end
      end
   end

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (move) begin
         hold_d       = asm_d;
         hold_valid_d = 1'b1;
      end else if (consume) begin
         hold_valid_d = 1'b0;
      end

      frame_cnt_d = frame_cnt_q;
      if (move && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;

      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         asm_q        <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         frame_cnt_q  <= frame_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign buffer_not_empty = hold_valid_q;
   assign ff_buffer        = hold_q;
   assign frame_count      = frame_cnt_q;
   assign drop_count       = drop_cnt_q;

endmodule

// File: tb/tb_ff_frame_assembler.sv
// Directed bench for ff_frame_assembler: delivery, back-pressure, short/long/restarted frames, reset.
module tb_ff_frame_assembler;

   localparam int unsigned FB = 41;
   localparam int unsigned FW = FB * 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_sop;
   logic          in_eop;
   logic          in_ready;
   logic          system_free;
   logic          buffer_not_empty;
   logic [FW-1:0] ff_buffer;
   logic [15:0]   frame_count;
   logic [15:0]   drop_count;

   int checks = 0;
   int errors = 0;

   ff_frame_assembler #(.FRAME_BYTES(FB), .CNT_W(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_sop           (in_sop),
      .in_eop           (in_eop),
      .in_ready         (in_ready),
      .system_free      (system_free),
      .buffer_not_empty (buffer_not_empty),
      .ff_buffer        (ff_buffer),
      .frame_count      (frame_count),
      .drop_count       (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected frame image: byte i = base+i, first byte in the top bits.
   function automatic logic [FW-1:0] frame_img(input logic [7:0] base);
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < FB; i++) f[(FB-1-i)*8 +: 8] = 8'(base + 8'(i));
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic s, input logic e);
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      tick();
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   // len bytes base..base+len-1, sop on the first, eop on the last when with_eop.
   task automatic send_frame(input logic [7:0] base, input int len, input logic with_eop);
      for (int i = 0; i < len; i++)
         send(8'(base + 8'(i)), i == 0, with_eop && (i == len - 1));
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_sop      = 1'b0;
      in_eop      = 1'b0;
      system_free = 1'b0;
      tick();
      reset = 1'b0;

      check("rst_bne", FW'(buffer_not_empty), FW'(0));
      check("rst_buf", ff_buffer, '0);
      check("rst_fc", FW'(frame_count), FW'(0));
      check("rst_dc", FW'(drop_count), FW'(0));
      check("rst_rdy", FW'(in_ready), FW'(1));

      // 1: single good frame, then consume
      send_frame(8'h00, 41, 1'b1);
      check("t1_bne", FW'(buffer_not_empty), FW'(1));
      check("t1_b0", FW'(ff_buffer[327:320]), FW'(8'h00));
      check("t1_b40", FW'(ff_buffer[7:0]), FW'(8'h28));
      check("t1_buf", ff_buffer, frame_img(8'h00));
      check("t1_fc", FW'(frame_count), FW'(1));
      system_free = 1'b1;
      tick();
      system_free = 1'b0;
      check("t1_bne_consumed", FW'(buffer_not_empty), FW'(0));
      check("t1_buf_kept", ff_buffer, frame_img(8'h00));

      // 2: back-to-back frames, second waits in PENDING
      do_reset();
      send_frame(8'h40, 41, 1'b1);
      send_frame(8'h80, 41, 1'b1);
      check("t2_rdy_pend", FW'(in_ready), FW'(0));
      check("t2_bne", FW'(buffer_not_empty), FW'(1));
      check("t2_buf_a", ff_buffer, frame_img(8'h40));
      check("t2_fc1", FW'(frame_count), FW'(1));
      system_free = 1'b1;
      tick();
      system_free = 1'b0;
      check("t2_bne_nobubble", FW'(buffer_not_empty), FW'(1));
      check("t2_buf_b", ff_buffer, frame_img(8'h80));
      check("t2_rdy", FW'(in_ready), FW'(1));
      check("t2_fc2", FW'(frame_count), FW'(2));

      // 3: short frame (eop on byte 20), lone sop+eop, then a good frame
      do_reset();
      send_frame(8'h10, 20, 1'b1);
      check("t3_dc", FW'(drop_count), FW'(1));
      check("t3_bne", FW'(buffer_not_empty), FW'(0));
      send(8'h55, 1'b1, 1'b1);
      check("t3_dc_single", FW'(drop_count), FW'(2));
      send_frame(8'h20, 41, 1'b1);
      check("t3_bne_good", FW'(buffer_not_empty), FW'(1));
      check("t3_buf", ff_buffer, frame_img(8'h20));
      check("t3_fc", FW'(frame_count), FW'(1));

      // 4: overlong frame (45 bytes), then a good frame
      do_reset();
      send_frame(8'h00, 41, 1'b0);
      check("t4_dc_at41", FW'(drop_count), FW'(1));
      for (int i = 41; i < 45; i++) begin
         check("t4_rdy_discard", FW'(in_ready), FW'(1));
         send(8'(i), 1'b0, i == 44);
      end
      check("t4_dc", FW'(drop_count), FW'(1));
      check("t4_bne", FW'(buffer_not_empty), FW'(0));
      check("t4_fc", FW'(frame_count), FW'(0));
      send_frame(8'h60, 41, 1'b1);
      check("t4_fc_after", FW'(frame_count), FW'(1));
      check("t4_buf_after", ff_buffer, frame_img(8'h60));

      // 5: stray bytes ignored, frame A interrupted by sop at its byte 10, frame B delivered
      do_reset();
      send(8'hEE, 1'b0, 1'b0);
      send(8'hEF, 1'b0, 1'b1);
      check("t5_dc_stray", FW'(drop_count), FW'(0));
      send_frame(8'hA0, 9, 1'b0);
      send_frame(8'hB0, 41, 1'b1);
      check("t5_dc", FW'(drop_count), FW'(1));
      check("t5_fc", FW'(frame_count), FW'(1));
      check("t5_buf", ff_buffer, frame_img(8'hB0));

      // 6: reset while PENDING with a held frame
      do_reset();
      send_frame(8'h01, 41, 1'b1);
      send_frame(8'h02, 41, 1'b1);
      check("t6_rdy_pend", FW'(in_ready), FW'(0));
      do_reset();
      check("t6_bne", FW'(buffer_not_empty), FW'(0));
      check("t6_buf", ff_buffer, '0);
      check("t6_fc", FW'(frame_count), FW'(0));
      check("t6_dc", FW'(drop_count), FW'(0));
      check("t6_rdy", FW'(in_ready), FW'(1));
      send_frame(8'h30, 41, 1'b1);
      check("t6_buf_after", ff_buffer, frame_img(8'h30));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
